// File: rtl/pricing_pkg.sv
// Shared types and constants for the pricing-core host sequencer.
package pricing_pkg;

    localparam int DATA_W = 12;
    localparam int MODE_W = 2;

    localparam int N_PATH_DEF        = 256;
    localparam int DAY_DEF           = 8;
    localparam int SOBOL_CYC_DEF     = 2001;
    localparam int PRICE_TIMEOUT_DEF = 65535;

    typedef logic [DATA_W-1:0] word_t;

    // Mode codes understood by the pricing core.
    typedef enum logic [MODE_W-1:0] {
        MODE_IDLE    = 2'd0,
        MODE_PARAM   = 2'd1,
        MODE_SOBOL   = 2'd2,
        MODE_PRICING = 2'd3
    } core_mode_e;

    // Host sequencer states.
    typedef enum logic [2:0] {
        H_IDLE,
        H_PARAM,
        H_SOBOL,
        H_COLLECT,
        H_PRICE,
        H_DONE
    } host_state_e;

    // Mode code presented to the core while the host sits in a given state.
    function automatic core_mode_e mode_of(host_state_e s);
        case (s)
            H_PARAM:   return MODE_PARAM;
            H_SOBOL:   return MODE_SOBOL;
            H_COLLECT: return MODE_SOBOL;
            H_PRICE:   return MODE_PRICING;
            default:   return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pricing_host_driver_if.sv
// Mode/data bus between the host sequencer and the pricing core.
interface pricing_host_driver_if;
    import pricing_pkg::*;

    logic [MODE_W-1:0] core_state;
    word_t             core_in;
    logic              core_valid;
    word_t             core_out;
    logic              core_resend;

    // Host side drives mode and data, listens to the core's output.
    modport master (
        output core_state, core_in,
        input  core_valid, core_out, core_resend
    );

    // Core side.
    modport slave (
        input  core_state, core_in,
        output core_valid, core_out, core_resend
    );
endinterface

// File: rtl/pricing_host_driver_path_buffer.sv
// Path capture buffer: synchronous write, registered read. The read address
// is presented one cycle ahead so rd_data tracks the address of the
// previous cycle.
module path_buffer
    import pricing_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  word_t             wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output word_t             rd_data
);

    word_t mem [DEPTH];
    word_t rd_data_q;

    // Write port and registered read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pricing_host_driver.sv
// Host-side sequencer: loads parameters into the pricing core, holds the
// Sobol warm-up, captures generated paths, replays them during pricing
// (restarting the current path on resend) and latches the final price.
module pricing_host_driver
    import pricing_pkg::*;
#(
    parameter int N_PATH        = N_PATH_DEF,
    parameter int DAY           = DAY_DEF,
    parameter int SOBOL_CYC     = SOBOL_CYC_DEF,
    parameter int PRICE_TIMEOUT = PRICE_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  word_t                 w_in,
    input  word_t                 q_in,
    input  word_t                 s0_in,
    input  word_t                 k_in,
    pricing_host_driver_if.master bus,
    output logic                  busy,
    output logic                  done,
    output word_t                 price,
    output logic                  error
);

    localparam int TOTAL   = N_PATH * DAY;
    localparam int ADDR_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int SOB_W   = $clog2(SOBOL_CYC + 1);
    localparam int CNT_W   = (SOB_W > 3) ? SOB_W : 3;
    localparam int TMO_W   = $clog2(PRICE_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] DAY_LAST   = ADDR_W'(DAY - 1);
    localparam logic [ADDR_W-1:0] DAY_STEP   = ADDR_W'(DAY);
    localparam logic [CNT_W-1:0]  PARAM_LAST = CNT_W'(4);
    localparam logic [CNT_W-1:0]  SOBOL_LAST = CNT_W'(SOBOL_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(PRICE_TIMEOUT - 1);

    host_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    word_t             prm_q [4];
    word_t             prm_d [4];
    word_t             core_in_q, core_in_d;
    word_t             price_q, price_d;
    logic              error_q, error_d;
    logic              done_q, done_d;
    logic              busy_q;
    logic [MODE_W-1:0] core_state_q;
    logic              wr_en;
    word_t             rd_data;

    path_buffer #(
        .DEPTH  (TOTAL),
        .ADDR_W (ADDR_W)
    ) u_path_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.core_out),
        .rd_addr (rd_ptr_d),
        .rd_data (rd_data)
    );

    // Next-state, pointer and output computation for the host sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        base_d    = base_q;
        tmo_d     = tmo_q;
        prm_d     = prm_q;
        core_in_d = '0;
        price_d   = price_q;
        error_d   = error_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;

        case (state_q)
            H_IDLE: begin
                if (start) begin
                    prm_d[0] = w_in;
                    prm_d[1] = q_in;
                    prm_d[2] = s0_in;
                    prm_d[3] = k_in;
                    error_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = H_PARAM;
                end
            end
            H_PARAM: begin
                // Slot 0 carries zero while the core leaves IDLE; slots 1..4
                // carry w, q, S0, K, so slot c+1 shows prm[c].
                if (cnt_q == PARAM_LAST) begin
                    cnt_d   = '0;
                    state_d = H_SOBOL;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    core_in_d = prm_q[cnt_q[1:0]];
                end
            end
            H_SOBOL: begin
                if (cnt_q == SOBOL_LAST) begin
                    wr_ptr_d = '0;
                    state_d  = H_COLLECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            H_COLLECT: begin
                if (bus.core_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        rd_ptr_d = '0;
                        base_d   = '0;
                        tmo_d    = '0;
                        state_d  = H_PRICE;
                    end
                end
            end
            H_PRICE: begin
                tmo_d = tmo_q + 1'b1;
                // A price beats a simultaneous resend; resend beats advance.
                if (bus.core_valid) begin
                    price_d = bus.core_out;
                    done_d  = 1'b1;
                    state_d = H_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = H_DONE;
                end else if (bus.core_resend) begin
                    rd_ptr_d = base_q;
                end else if (rd_ptr_q == LAST_ADDR) begin
                    rd_ptr_d = '0;
                    base_d   = '0;
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q - base_q == DAY_LAST) begin
                        base_d = base_q + DAY_STEP;
                    end
                end
            end
            H_DONE: begin
                state_d = H_IDLE;
            end
            default: begin
                state_d = H_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs are derived from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= H_IDLE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            base_q       <= '0;
            tmo_q        <= '0;
            prm_q        <= '{default: '0};
            core_in_q    <= '0;
            core_state_q <= MODE_IDLE;
            price_q      <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            base_q       <= base_d;
            tmo_q        <= tmo_d;
            prm_q        <= prm_d;
            core_in_q    <= core_in_d;
            core_state_q <= mode_of(state_d);
            price_q      <= price_d;
            error_q      <= error_d;
            done_q       <= done_d;
            busy_q       <= (state_d != H_IDLE);
        end
    end

    // During pricing the buffer word for rd_ptr is already on the RAM output.
    assign bus.core_state = core_state_q;
    assign bus.core_in    = (state_q == H_PRICE) ? rd_data : core_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign price          = price_q;
    assign error          = error_q;

endmodule

// File: tb/tb_pricing_host_driver.sv
// Randomized scoreboard bench for pricing_host_driver with reduced sizes.
module tb_pricing_host_driver;
    import pricing_pkg::*;

    localparam int NP    = 4;
    localparam int DY    = 8;
    localparam int SC    = 10;
    localparam int PTO   = 50;
    localparam int TOTAL = NP * DY;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] data;
    } exp_word_t;

    typedef struct {
        logic        d;
        logic        e;
        logic [11:0] p;
    } exp_res_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] w_in, q_in, s0_in, k_in;
    logic        busy, done, error;
    logic [11:0] price;

    pricing_host_driver_if bus ();

    pricing_host_driver #(
        .N_PATH        (NP),
        .DAY           (DY),
        .SOBOL_CYC     (SC),
        .PRICE_TIMEOUT (PTO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .w_in  (w_in),
        .q_in  (q_in),
        .s0_in (s0_in),
        .k_in  (k_in),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .price (price),
        .error (error)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    bit          mon_en   = 0;
    exp_word_t   word_q[$];
    exp_res_t    res_q[$];
    logic [11:0] mem [TOTAL];
    logic [11:0] last_price;
    logic        last_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops an expected word whenever the core is being driven with
    // data, and an expected result on the single DONE cycle.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            #2;
            if (bus.core_state == MODE_PARAM || bus.core_state == MODE_PRICING) begin
                if (word_q.size() == 0) begin
                    check("unexpected_word", {bus.core_state, bus.core_in}, 0);
                end else begin
                    exp_word_t e;
                    e = word_q.pop_front();
                    check(bus.core_state == MODE_PARAM ? "param_word" : "price_word",
                          {bus.core_state, bus.core_in}, {e.mode, e.data});
                end
            end
            if (busy && bus.core_state == MODE_IDLE) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_res_t r;
                    r = res_q.pop_front();
                    check("done_pulse", done, r.d);
                    check("error_flag", error, r.e);
                    check("price", price, r.p);
                    $display("result: done=%0b error=%0b price=0x%03h", done, error, price);
                end
            end
        end
    end

    // One start-to-finish job. mode 0: price at cycle vcyc, no resend;
    // mode 1: resend at word 0x00D, then resend+valid at a path end;
    // mode 2: random resends, price at vcyc (timeout if vcyc > PTO);
    // mode 3: reset halfway through collection.
    task automatic run_job(input logic [11:0] w, input logic [11:0] q,
                           input logic [11:0] s, input logic [11:0] k,
                           input int mode, input bit idx_data,
                           input int vcyc, input logic [11:0] pval);
        int  n2, nw, ccyc, np, path, day, fin;
        bit  in_price, resent, rst_sent, do_valid, do_resend;
        logic [11:0] wd;
        n2 = 0; nw = 0; ccyc = 0; np = 0; path = 0; day = 0; fin = 0;
        in_price = 0; resent = 0; rst_sent = 0;
        for (int i = 0; i < TOTAL; i++)
            mem[i] = idx_data ? 12'(i) : 12'($urandom_range(0, 4095));

        @(negedge clk);
        start = 1'b1; w_in = w; q_in = q; s0_in = s; k_in = k;
        word_q.push_back('{MODE_PARAM, 12'h000});
        word_q.push_back('{MODE_PARAM, w});
        word_q.push_back('{MODE_PARAM, q});
        word_q.push_back('{MODE_PARAM, s});
        word_q.push_back('{MODE_PARAM, k});
        @(negedge clk);
        start = 1'b0;

        for (int cyc = 0; cyc < 400 && fin == 0; cyc++) begin
            @(negedge clk);
            bus.core_valid  = 1'b0;
            bus.core_resend = 1'b0;
            bus.core_out    = 12'($urandom_range(0, 4095));
            if (rst_sent) begin
                check("rst_core_state", bus.core_state, 0);
                check("rst_busy", busy, 0);
                check("rst_error", error, 0);
                check("rst_done", done, 0);
                rst = 1'b0;
                last_price = 12'h000;
                last_err = 1'b0;
                fin = 2;
            end else if (bus.core_state == MODE_PARAM) begin
                bus.core_valid = 1'($urandom_range(0, 1));
            end else if (bus.core_state == MODE_SOBOL) begin
                n2++;
                if (n2 <= SC) begin
                    bus.core_valid = 1'b1;
                    bus.core_out   = 12'hFFF;
                end else if (nw < TOTAL) begin
                    ccyc++;
                    if ($urandom_range(0, 2) != 0) begin
                        bus.core_valid = 1'b1;
                        bus.core_out   = mem[nw];
                        nw++;
                    end
                    if (mode == 3 && nw == TOTAL / 2) begin
                        rst = 1'b1;
                        rst_sent = 1;
                    end
                end
            end else if (bus.core_state == MODE_PRICING) begin
                if (!in_price) begin
                    in_price = 1;
                    check("sobol_collect_len", n2, SC + ccyc);
                end
                np++;
                wd = mem[path * DY + day];
                word_q.push_back('{MODE_PRICING, wd});
                do_valid = 0;
                do_resend = 0;
                case (mode)
                    0: do_valid = (np == vcyc);
                    1: begin
                        if (!resent && wd == 12'h00D) begin
                            do_resend = 1;
                            resent = 1;
                        end else if (resent && day == DY - 1) begin
                            do_resend = 1;
                            do_valid = 1;
                        end
                    end
                    default: begin
                        do_resend = ($urandom_range(0, 3) == 0);
                        do_valid = (np == vcyc);
                    end
                endcase
                bus.core_valid  = do_valid;
                bus.core_resend = do_resend;
                if (do_valid) begin
                    bus.core_out = pval;
                    res_q.push_back('{1'b1, 1'b0, pval});
                    last_price = pval;
                    last_err = 1'b0;
                    fin = 1;
                end else if (np == PTO) begin
                    res_q.push_back('{1'b0, 1'b1, last_price});
                    last_err = 1'b1;
                    fin = 1;
                end else if (do_resend) begin
                    day = 0;
                end else begin
                    day++;
                    if (day == DY) begin
                        day = 0;
                        path = (path + 1) % NP;
                    end
                end
            end
        end

        if (fin == 1) begin
            @(negedge clk);
            bus.core_valid  = 1'b0;
            bus.core_resend = 1'b0;
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_core_state", bus.core_state, 0);
            check("idle_error", error, last_err);
            check("idle_price", price, last_price);
        end else if (fin == 0) begin
            check("job_bound", 0, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            word_q.delete();
            res_q.delete();
            last_price = 12'h000;
            last_err = 1'b0;
        end
        $display("job mode=%0d finished: price_cycles=%0d collect_words=%0d", mode, np, nw);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        w_in = '0; q_in = '0; s0_in = '0; k_in = '0;
        bus.core_valid = 1'b0; bus.core_resend = 1'b0; bus.core_out = '0;
        last_price = 12'h000;
        last_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_core_state", bus.core_state, 0);
        check("reset_core_in", bus.core_in, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_price", price, 0);
        check("reset_error", error, 0);
        rst = 1'b0;
        mon_en = 1;

        run_job(12'h123, 12'h045, 12'h800, 12'h7F0, 0, 1, TOTAL + 4, 12'h3A5);
        run_job(12'h0AA, 12'h055, 12'h400, 12'h3FF, 1, 1, 0, 12'($urandom_range(0, 4095)));
        run_job(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 2, 0, 30,
                12'($urandom_range(0, 4095)));
        run_job(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 2, 0, 999, 12'h5A5);
        run_job(12'h111, 12'h222, 12'h333, 12'h444, 3, 1, 0, 12'h000);
        run_job(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 2, 0, 20,
                12'($urandom_range(0, 4095)));

        repeat (3) @(negedge clk);
        check("word_queue_empty", word_q.size(), 0);
        check("result_queue_empty", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pricing_host_driver.md
Name: pricing_host_driver

Overview:
- Host-side sequencer for the option-pricing core's 2-bit mode / 12-bit data bus.
- Drives the mode code and data word into the core, captures the generated paths into an internal buffer, and replays them during pricing, restarting the current path on every resend request.
- Latches the final price, then returns the core to IDLE.
- Sits between the chip-level test harness (or CPU bridge) and the pricing core.

Parameters:
- N_PATH, 256, number of Monte-Carlo paths.
- DAY, 8, words (days) per path.
- SOBOL_CYC, 2001, cycles mode 2 is held before path collection begins.
- PRICE_TIMEOUT, 65535, max cycles in pricing before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; ignored unless idle.
- w_in  in  12  parameter w.
- q_in  in  12  parameter q.
- s0_in  in  12  parameter S0.
- k_in  in  12  parameter K.
- core_state  out  2  mode code to core (0 IDLE, 1 PARAM, 2 SOBOL, 3 PRICING).
- core_in  out  12  data word to core.
- core_valid  in  1  core output qualifier.
- core_out  in  12  core output word (path word or price).
- core_resend  in  1  core requests the current path again.
- busy  out  1  high from start accept until done/error.
- done  out  1  one-cycle pulse when the price is latched.
- price  out  12  latched price, held until the next start.
- error  out  1  sticky until next start; pricing timeout.

Behaviour:
- Reset: FSM=H_IDLE; core_state=0; core_in=0; busy=0; done=0; price=0; error=0; all counters 0. Buffer contents are not reset.
- H_IDLE: core_state=0. On start: latch w/q/s0/k, clear error, go H_PARAM with cnt=0.
- H_PARAM (5 cycles, core_state=1):
  - cnt0: core_in=0, while the core leaves IDLE.
  - cnt1..4: core_in = w, q, S0, K in that order.
  - After cnt4 go H_SOBOL with cnt=0.
- H_SOBOL: core_state=2, core_in=0 for SOBOL_CYC cycles, then go H_COLLECT with wr_ptr=0.
- H_COLLECT: core_state stays 2.
  - Each cycle core_valid=1: buf[wr_ptr]<=core_out, wr_ptr++.
  - When wr_ptr reaches N_PATH*DAY: go H_PRICE with rd_ptr=0, path_base=0, tmo=0.
  - core_valid words arriving in H_COLLECT beyond capacity cannot occur (the state exits first). Valid words in any other state are ignored, except in H_PRICE.
- H_PRICE: core_state=3, core_in=buf[rd_ptr].
  - Buffer is read combinationally or with a 1-cycle-ahead registered read; either way core_in must present word rd_ptr in the same cycle rd_ptr is current.
  - Normal step: rd_ptr++. When rd_ptr-path_base == DAY-1, path_base += DAY.
  - Wrap: after the last word (N_PATH*DAY-1), rd_ptr and path_base wrap to 0.
  - core_resend=1: next rd_ptr = path_base (restart current path). Resend has priority over advance and wrap.
  - core_valid=1 and core_resend=1 in the same cycle: valid wins. price<=core_out, go H_DONE.
  - core_valid=1 alone: price<=core_out, go H_DONE.
  - tmo increments every cycle. At PRICE_TIMEOUT: error<=1, go H_DONE without updating price.
- H_DONE (1 cycle): core_state=0; done=1 only if no error; busy=0 next cycle; return to H_IDLE.
- busy is 1 in every state except H_IDLE.
- rst mid-operation: immediate return to reset values next edge. core_state=0 forces the core back to idle.
- start while busy: ignored.

Decomposition:
- Shared package (pricing_pkg):
  - core mode codes MODE_IDLE/PARAM/SOBOL/PRICING.
  - Data width 12.
  - Host FSM state enum.
- One sub-module: path_buffer, a single-port-write / single-port-read RAM of N_PATH*DAY x 12 with a synchronous write and the read style chosen above.

Test Plan:
- Param sequence: start with w=0x123, q=0x045, s0=0x800, k=0x7F0 -> core_state = 1 for exactly 5 cycles; core_in = 0, 0x123, 0x045, 0x800, 0x7F0; then core_state=2.
- Sobol hold and capture (reduced parameters N_PATH=4, DAY=8, SOBOL_CYC=10): core_state=2 for 10 cycles. Model emits 32 valid words 0x000..0x01F with gaps -> buffer holds 0..0x1F; core_state becomes 3 the cycle after the 32nd word.
- Replay and wrap: no resend -> core_in sequence 0x000..0x01F, then 0x000 again.
- Resend: assert resend while core_in=0x00D (path 1, day 5) -> next core_in=0x008. Assert resend and valid together at a path boundary -> price latched, no restart.
- Price: core_valid=1, core_out=0x3A5 in pricing -> price=0x3A5, done pulse 1 cycle, core_state=0, busy=0.
- Timeout and reset: PRICE_TIMEOUT=50 with no valid -> error=1, done=0, price unchanged. Separately, assert rst mid-H_COLLECT -> next cycle core_state=0, busy=0, error=0.
